// File: rtl/dual_edge_counter_param.sv
// ---------------------------------------------------------------------------
// dual_edge_counter_param
//
// Counter that advances on both the rising and the falling edge of clk, so it
// produces two counts per clock period. Width, modulus (MAX_VAL) and the
// behaviour at the limits (wrap or saturate) are parameters; direction, count
// enable and a synchronous load are run-time controls.
//
// Parameters:
//   WIDTH     counter width in bits (2..32)
//   MAX_VAL   highest count value (1..2**WIDTH-1)
//   SATURATE  0 = wrap at the limits, 1 = hold at the limits
//
// Ports:
//   clk       system clock, both edges active
//   rst       asynchronous reset, active low
//   en        count enable, sampled on every edge
//   up        direction (1 = increment, 0 = decrement), sampled on every edge
//   load      synchronous load, sampled on the rising edge only
//   load_val  value to load, clamped to MAX_VAL
//   out       current count
//   tc        terminal count: en & (up ? out==MAX_VAL : out==0), combinational
//   wrap      high for the half-period after an edge on which the count wrapped
//   ovf       sticky overflow, set on any wrap or saturation event,
//             cleared by load or reset
// ---------------------------------------------------------------------------
module dual_edge_counter_param #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter int               SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  // Reject parameter sets the counter cannot honour.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("dual_edge_counter_param: WIDTH must be in 2..32");
  end
  if (MAX_VAL == '0) begin : g_bad_max
    $error("dual_edge_counter_param: MAX_VAL must be at least 1");
  end

  localparam bit SAT = (SATURATE != 0);

  // Each visible quantity is split into a rising-edge half (_p) and a
  // falling-edge half (_n); the visible value is their XOR. Writing
  // (next ^ other_half) into the half owned by the current edge makes the
  // XOR equal to next, without gated clocks or muxing on the clock level.
  logic [WIDTH-1:0] cnt_p;
  logic [WIDTH-1:0] cnt_n;
  logic             wrap_p;
  logic             wrap_n;
  logic             ovf_p;
  logic             ovf_n;

  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] step_val;
  logic             step_wrap;
  logic             step_sat;
  logic [WIDTH-1:0] load_clamped;

  logic [WIDTH-1:0] rise_val;
  logic             rise_wrap;
  logic             rise_ovf;
  logic [WIDTH-1:0] fall_val;
  logic             fall_wrap;
  logic             fall_ovf;

  assign out  = cnt_p ^ cnt_n;
  assign wrap = wrap_p ^ wrap_n;
  assign ovf  = ovf_p ^ ovf_n;

  assign at_max  = (out == MAX_VAL);
  assign at_zero = (out == '0);

  assign tc = en & (up ? at_max : at_zero);

  // A load can never place the count above MAX_VAL.
  assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  // Counting step shared by both edges: the value one count on from the
  // current output, plus whether reaching it is a wrap or a saturation event.
  always_comb begin
    step_val  = out;
    step_wrap = 1'b0;
    step_sat  = 1'b0;
    if (en) begin
      if (up) begin
        if (!at_max) begin
          step_val = out + WIDTH'(1);
        end else if (SAT) begin
          step_val = MAX_VAL;
          step_sat = 1'b1;
        end else begin
          step_val  = '0;
          step_wrap = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          step_val = out - WIDTH'(1);
        end else if (SAT) begin
          step_val = '0;
          step_sat = 1'b1;
        end else begin
          step_val  = MAX_VAL;
          step_wrap = 1'b1;
        end
      end
    end
  end

  // Rising edge: a load takes priority over counting, clears both flags and
  // never raises an event, even when the count sits at a limit.
  always_comb begin
    rise_val  = step_val;
    rise_wrap = step_wrap;
    rise_ovf  = ovf | step_wrap | step_sat;
    if (load) begin
      rise_val  = load_clamped;
      rise_wrap = 1'b0;
      rise_ovf  = 1'b0;
    end
  end

  // Falling edge: load is not looked at here, so this edge only counts.
  always_comb begin
    fall_val  = step_val;
    fall_wrap = step_wrap;
    fall_ovf  = ovf | step_wrap | step_sat;
  end

  // Rising-edge halves. Reset clears both halves so the visible values drop
  // to zero at once, whatever the clock phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_p  <= '0;
      wrap_p <= 1'b0;
      ovf_p  <= 1'b0;
    end else begin
      cnt_p  <= rise_val ^ cnt_n;
      wrap_p <= rise_wrap ^ wrap_n;
      ovf_p  <= rise_ovf ^ ovf_n;
    end
  end

  // Falling-edge halves.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      cnt_n  <= '0;
      wrap_n <= 1'b0;
      ovf_n  <= 1'b0;
    end else begin
      cnt_n  <= fall_val ^ cnt_p;
      wrap_n <= fall_wrap ^ wrap_p;
      ovf_n  <= fall_ovf ^ ovf_p;
    end
  end

endmodule
